// File: rtl/branch_unit_bht.sv
// Branch resolution unit: evaluates SB-type conditions in EX, computes the redirect target,
// serves 2-bit BHT predictions to IF and keeps saturating branch/mispredict statistics.
module branch_unit_bht #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [31:0]          Instruction,
  input  logic [XLEN-1:0]      rs1Data,
  input  logic [XLEN-1:0]      rs2Data,
  input  logic                 ex_pred_taken,
  output logic                 Branch,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int unsigned Entries = 1 << BHT_IDX_BITS;

  logic [1:0]           bht_q [Entries];
  logic [1:0]           bht_d [Entries];
  logic                 branch_q, branch_d;
  logic                 mispredict_q, mispredict_d;
  logic [XLEN-1:0]      redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic [BHT_IDX_BITS-1:0] if_idx, ex_idx;
  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    is_branch;
  logic                    taken;
  logic [XLEN:0]           diff;
  logic                    eq, lt_u, lt_s;
  logic [XLEN-1:0]         imm_b, target, fall_through;
  logic                    unused_bits;

  assign if_idx = if_pc[BHT_IDX_BITS+1:2];
  assign ex_idx = ex_pc[BHT_IDX_BITS+1:2];
  assign if_pred_taken = bht_q[if_idx][1];

  assign opcode    = Instruction[6:0];
  assign funct3    = Instruction[14:12];
  assign is_branch = ex_valid && (opcode == 7'b1100011) && (funct3 != 3'd2) && (funct3 != 3'd3);

  // One subtractor serves all compares; carry-out set means no borrow (rs1 >= rs2 unsigned).
  assign diff = {1'b0, rs1Data} + {1'b0, ~rs2Data} + {{XLEN{1'b0}}, 1'b1};
  assign eq   = (diff[XLEN-1:0] == '0);
  assign lt_u = ~diff[XLEN];
  assign lt_s = (rs1Data[XLEN-1] ^ rs2Data[XLEN-1]) ? rs1Data[XLEN-1] : diff[XLEN-1];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'd0:    taken = eq;
      3'd1:    taken = ~eq;
      3'd4:    taken = lt_s;
      3'd5:    taken = ~lt_s;
      3'd6:    taken = lt_u;
      3'd7:    taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

  assign imm_b = {{(XLEN-13){Instruction[31]}}, Instruction[31], Instruction[7],
                  Instruction[30:25], Instruction[11:8], 1'b0};
  assign target       = ex_pc + imm_b;
  assign fall_through = ex_pc + XLEN'(4);

  always_comb begin
    bht_d        = bht_q;
    branch_d     = 1'b0;
    mispredict_d = 1'b0;
    redirect_d   = redirect_q;
    br_cnt_d     = br_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (is_branch) begin
      branch_d     = taken;
      mispredict_d = (taken != ex_pred_taken);
      redirect_d   = taken ? target : fall_through;
      if (br_cnt_q != {CNT_WIDTH{1'b1}}) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
      if (mispredict_d && (miss_cnt_q != {CNT_WIDTH{1'b1}})) begin
        miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
      end
      if (taken && (bht_q[ex_idx] != 2'b11)) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else if (!taken && (bht_q[ex_idx] != 2'b00)) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) bht_q[i] <= 2'b01;
      branch_q     <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      bht_q        <= bht_d;
      branch_q     <= branch_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign Branch      = branch_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign br_count    = br_cnt_q;
  assign miss_count  = miss_cnt_q;

  assign unused_bits = ^{Instruction[24:15], if_pc[XLEN-1:BHT_IDX_BITS+2], if_pc[1:0],
                         ex_pc[1:0]};

endmodule

// File: tb/tb_branch_unit_bht.sv
// Scoreboard bench for branch_unit_bht: a behavioural model pushes expected outputs per
// driven cycle; tasks pop and compare after each clock edge.
module tb_branch_unit_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, ex_pc, Instruction, rs1Data, rs2Data;
  logic        ex_valid, ex_pred_taken;
  logic        if_pred_taken, Branch, mispredict;
  logic [31:0] redirect_pc, br_count, miss_count;
  logic        if_pred_taken4, branch4, mispredict4;
  logic [31:0] redirect_pc4;
  logic [3:0]  br_count4, miss_count4;

  branch_unit_bht dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .Instruction(Instruction), .rs1Data(rs1Data),
    .rs2Data(rs2Data), .ex_pred_taken(ex_pred_taken), .Branch(Branch),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .br_count(br_count),
    .miss_count(miss_count)
  );

  branch_unit_bht #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken4),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .Instruction(Instruction), .rs1Data(rs1Data),
    .rs2Data(rs2Data), .ex_pred_taken(ex_pred_taken), .Branch(branch4),
    .mispredict(mispredict4), .redirect_pc(redirect_pc4), .br_count(br_count4),
    .miss_count(miss_count4)
  );

  always #5 clk = ~clk;

  wire [105:0] obs = {Branch, mispredict, redirect_pc, br_count, miss_count,
                      br_count4, miss_count4};

  int          tests = 0;
  int          fails = 0;
  logic [105:0] sb[$];
  logic [105:0] e;
  logic [1:0]  m_bht [64];
  logic        m_b, m_mp;
  logic [31:0] m_rd, m_br, m_miss;
  logic [3:0]  m_br4, m_miss4;

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one EX cycle and advance the reference model.
  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b, input logic pt);
    logic        br, tk;
    logic [31:0] imm;
    logic [5:0]  ix;
    ex_valid = v; ex_pc = pc; Instruction = ins; rs1Data = a; rs2Data = b; ex_pred_taken = pt;
    br = v && (ins[6:0] == 7'b1100011) && (ins[14:12] inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7});
    case (ins[14:12])
      3'd0:    tk = (a == b);
      3'd1:    tk = (a != b);
      3'd4:    tk = ($signed(a) < $signed(b));
      3'd5:    tk = ($signed(a) >= $signed(b));
      3'd6:    tk = (a < b);
      3'd7:    tk = (a >= b);
      default: tk = 1'b0;
    endcase
    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ix  = pc[7:2];
    if (br) begin
      m_b  = tk;
      m_mp = (tk != pt);
      m_rd = tk ? pc + imm : pc + 32'd4;
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
      if (m_br4 != 4'hF) m_br4 = m_br4 + 4'd1;
      if (m_mp && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
      if (m_mp && m_miss4 != 4'hF) m_miss4 = m_miss4 + 4'd1;
      if (tk && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'b01;
      else if (!tk && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'b01;
    end else begin
      m_b  = 1'b0;
      m_mp = 1'b0;
    end
    sb.push_back({m_b, m_mp, m_rd, m_br, m_miss, m_br4, m_miss4});
  endtask

  task automatic do_reset(input logic with_br);
    if (with_br) begin
      ex_valid = 1'b1; ex_pc = 32'h300; Instruction = enc_b(3'd0, 13'd16);
      rs1Data = 32'd0; rs2Data = 32'd0; ex_pred_taken = 1'b0;
    end
    rst = 1'b1;
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_b = 0; m_mp = 0; m_rd = 0; m_br = 0; m_miss = 0; m_br4 = 0; m_miss4 = 0;
    sb.push_back('0);
    tick();
    rst = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset(1'b0);
    e = sb.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_outputs: got %h want %h", obs, e); end
    if_pc = 32'h40; #1; tests++;
    if (if_pred_taken !== 1'b0) begin
      fails++; $display("FAIL reset_pred: got %b want 0", if_pred_taken);
    end
    for (int i = 0; i < 64; i++) if (dut.bht_q[i] !== 2'b01) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_bht: got %0d bad entries want 0", bad); end
  endtask

  task automatic test_beq();
    set_ex(1'b1, 32'h100, enc_b(3'd0, 13'd16), 32'd5, 32'd5, 1'b0);
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL beq_taken: got %h want %h", obs, e); end
    tests++;
    if (dut.bht_q[0] !== 2'b10) begin
      fails++; $display("FAIL beq_bht: got %b want 10", dut.bht_q[0]);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_compares();
    logic [2:0]  f3 [3] = '{3'd4, 3'd6, 3'd5};
    logic [31:0] a  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b  [3] = '{32'd1, 32'd1, 32'h7FFF_FFFF};
    logic        pt [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h180, enc_b(f3[i], 13'd40), a[i], b[i], pt[i]);
      tick();
      e = sb.pop_front(); tests++;
      if (obs !== e || mispredict !== 1'b0) begin
        fails++; $display("FAIL compare_%0d: got %h want %h", i, obs, e);
      end
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_bht_saturation();
    logic want_p [3] = '{1'b0, 1'b1, 1'b1};
    do_reset(1'b0);
    void'(sb.pop_front());
    if_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h200, enc_b(3'd1, 13'd8), 32'd1, 32'd2, 1'b1);
      #1; tests++;
      if (if_pred_taken !== want_p[i]) begin
        fails++; $display("FAIL bht_pred_%0d: got %b want %b", i, if_pred_taken, want_p[i]);
      end
      tick();
      e = sb.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL bne_taken_%0d: got %h want %h", i, obs, e); end
    end
    tests++;
    if (dut.bht_q[0] !== 2'b11) begin
      fails++; $display("FAIL bht_sat: got %b want 11", dut.bht_q[0]);
    end
    set_ex(1'b1, 32'h200, enc_b(3'd1, 13'd8), 32'd3, 32'd3, 1'b1);
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL bne_not_taken: got %h want %h", obs, e); end
    tests++;
    if (dut.bht_q[0] !== 2'b10) begin
      fails++; $display("FAIL bht_dec: got %b want 10", dut.bht_q[0]);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_backward_and_nonbranch();
    int bad = 0;
    set_ex(1'b1, 32'h10, enc_b(3'd0, 13'h1FE0), 32'd9, 32'd9, 1'b0);
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e || redirect_pc !== 32'hFFFF_FFF0) begin
      fails++; $display("FAIL backward: got %h want %h", obs, e);
    end
    set_ex(1'b1, 32'h10, enc_b(3'd2, 13'd16), 32'd9, 32'd9, 1'b1);
    tick();
    e = sb.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL funct3_2: got %h want %h", obs, e); end
    for (int i = 0; i < 64; i++) if (dut.bht_q[i] !== m_bht[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL nonbranch_bht: got %0d bad entries want 0", bad); end
    ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back_saturation();
    int bad = 0;
    do_reset(1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      set_ex(1'b1, 32'h300 + 32'(i * 4), enc_b(3'd0, 13'd16), 32'd7, 32'd7, 1'b0);
      tick();
      e = sb.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL b2b_%0d: got %h want %h", i, obs, e); end
    end
    tests++;
    if (br_count4 !== 4'hF || miss_count4 !== 4'hF) begin
      fails++; $display("FAIL cnt4_sat: got %h/%h want f/f", br_count4, miss_count4);
    end
    do_reset(1'b1);
    e = sb.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_with_branch: got %h want %h", obs, e); end
    for (int i = 0; i < 64; i++) if (dut.bht_q[i] !== 2'b01) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_bht2: got %0d bad entries want 0", bad); end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; Instruction = '0; rs1Data = '0; rs2Data = '0;
    ex_pred_taken = 1'b0; if_pc = '0;
    test_reset();
    test_beq();
    test_compares();
    test_bht_saturation();
    test_backward_and_nonbranch();
    test_back_to_back_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
